pipe_hazard_ctrl: RTL
=====================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Parametrised hazard/forwarding controller for the in-order xgriscv pipeline; successor to the
//  fixed 5-stage datapath's flush-only control. Tracks a valid/rd scoreboard for NSTAGE stages
//  after decode (stage 1=E ... NSTAGE=W) and generates E-stage bypass selects, load-use stall,
//  branch-flush bubbles, a global hold and a stall-cycle counter. Sits beside the datapath.
// PARAMETERS
//  NSTAGE        3   stages after decode (E,M,W); legal 2..6; stage NSTAGE writes regfile
//  RFIDX_WIDTH   5   register index width
//  LOAD_RDY      3   first stage holding load data; legal 2..NSTAGE (ALU results ready at stage 2)
//  SELW  $clog2(NSTAGE+1)  bypass select width (localparam)
// PORTS
//  clk         in   1       clock
//  reset       in   1       async active-high reset
//  valid_d     in   1       decode holds a real instruction
//  rs1_d       in   RFIDX   decode source 1 (rs2_d likewise)
//  rd_d        in   RFIDX   decode destination
//  regwrite_d  in   1       decode writes rd
//  memtoreg_d  in   1       decode is a load
//  flush_i     in   1       branch/jump taken in E (pcsrc)
//  hold_i      in   1       freeze all stages (memory wait)
//  stall_d     out  1       hold PC and IF/ID; insert bubble into E
//  valid_o     out  NSTAGE  per-stage valid, bit k-1 = stage k
//  fwd_a_e     out  SELW    E operand A source: 0=regfile, k=stage k result
//  fwd_b_e     out  SELW    E operand B source, same encoding
//  fwd_err     out  1       E source hits an unready producer (must never assert)
//  stall_cnt   out  32      count of cycles with stall_d=1
// BEHAVIOUR
//  - Reset (async): all stage valid/rd/rs/regwrite/memtoreg cleared; outputs 0; stall_cnt=0.
//  - State per stage k: valid, rd, rs1, rs2, regwrite, memtoreg. Advance when hold_i=0:
//    stage k+1<=stage k (k>=1); stage 1 <= decode fields with valid=valid_d&~stall_d&~flush_i.
//    Stage NSTAGE retires. hold_i=1: every register keeps value; stall_cnt frozen.
//  - Load-use stall (comb.): stall_d=valid_d & ~flush_i & exists k in 1..NSTAGE-1: stage k valid,
//    regwrite, memtoreg, rd!=0, rd==rs1_d or rs2_d, and k+1<LOAD_RDY. Decode reg compare uses
//    rs2_d regardless of format (conservative stall is acceptable).
//  - Bypass (comb., from stage 1 regs): for each E source, scan k=2..NSTAGE youngest first; first
//    stage with valid & regwrite & rd!=0 & rd==src wins. If k<LOAD_RDY and memtoreg -> fwd_err=1,
//    select still k. No match or src==0 -> 0. Stage-1 valid=0 -> selects 0, fwd_err 0.
//  - Regfile must be write-first or the W bypass (k=NSTAGE) covers same-cycle read.
//  - Flush: flush_i overrides stall (stall_d=0); incoming E entry becomes bubble; stages >=2 keep
//    advancing. flush_i with hold_i: no effect that cycle; controller must keep flush_i asserted.
//  - stall_cnt increments by 1 on each clock where stall_d=1 & hold_i=0; wraps 2^32-1 -> 0.
//  - Reset mid-operation clears scoreboard instantly; first post-reset cycle has no forwarding.
//  - Latency: scoreboard 1 cycle/stage; all outputs combinational from registers/decode inputs.
// TESTING
//  1 add x5 then add x6,x5,x1 back-to-back -> next cycle fwd_a_e=2, stall_d=0 throughout.
//  2 lw x5 then add x6,x5,x5 -> stall_d=1 one cycle, stall_cnt=1, bubble (valid_o[0]=0), then
//    fwd_a_e=fwd_b_e=3 (LOAD_RDY=3).
//  3 Producers x7 in stages 2 and 3, consumer rs2=x7 -> fwd_b_e=2 (youngest wins); rd=x0 -> 0.
//  4 lw x5 in E, dependent in D, flush_i=1 same cycle -> stall_d=0, E entry bubble, cnt unchanged.
//  5 hold_i=1 for 4 cycles mid-stream -> valid_o/selects frozen; resumes identically after.
//  6 NSTAGE=5, LOAD_RDY=4: load/use distance 1 and 2 -> 2 and 1 stall cycles; fwd_err never 1;
//    async reset asserted mid-stall -> valid_o=0, stall_cnt=0 without clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and forwarding controller for the in-order xgriscv pipeline.
// Tracks a per-stage scoreboard after decode and drives bypass, stall and flush.
module pipe_hazard_ctrl #(
    parameter int NSTAGE      = 3,
    parameter int RFIDX_WIDTH = 5,
    parameter int LOAD_RDY    = 3,
    localparam int SELW       = $clog2(NSTAGE + 1)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_d,
    input  logic [RFIDX_WIDTH-1:0] rs1_d,
    input  logic [RFIDX_WIDTH-1:0] rs2_d,
    input  logic [RFIDX_WIDTH-1:0] rd_d,
    input  logic                   regwrite_d,
    input  logic                   memtoreg_d,
    input  logic                   flush_i,
    input  logic                   hold_i,
    output logic                   stall_d,
    output logic [NSTAGE-1:0]      valid_o,
    output logic [SELW-1:0]        fwd_a_e,
    output logic [SELW-1:0]        fwd_b_e,
    output logic                   fwd_err,
    output logic [31:0]            stall_cnt
);

    typedef struct packed {
        logic                   valid;
        logic [RFIDX_WIDTH-1:0] rd;
        logic [RFIDX_WIDTH-1:0] rs1;
        logic [RFIDX_WIDTH-1:0] rs2;
        logic                   regWrite;
        logic                   memToReg;
    } stage_t;

    stage_t stages [1:NSTAGE];

    logic            loadHit;
    logic [SELW-1:0] selA;
    logic [SELW-1:0] selB;
    logic            errA;
    logic            errB;

    function automatic logic prodHit(
        input stage_t                 s,
        input logic [RFIDX_WIDTH-1:0] src
    );
        return s.valid && s.regWrite && (s.rd != '0) && (s.rd == src);
    endfunction

    // Stage 1 takes decode; older stages shift down and the last one retires.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                stages[k] <= '0;
            end
        end else if (!hold_i) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                stages[k] <= stages[k-1];
            end
            stages[1].valid    <= valid_d & ~stall_d & ~flush_i;
            stages[1].rd       <= rd_d;
            stages[1].rs1      <= rs1_d;
            stages[1].rs2      <= rs2_d;
            stages[1].regWrite <= regwrite_d;
            stages[1].memToReg <= memtoreg_d;
        end
    end

    // A load in stage k reaches stage k+1 when the consumer enters E.
    always_comb begin
        loadHit = 1'b0;
        for (int k = 1; k <= NSTAGE - 1; k++) begin
            if ((k + 1 < LOAD_RDY) && stages[k].memToReg &&
                (prodHit(stages[k], rs1_d) || prodHit(stages[k], rs2_d))) begin
                loadHit = 1'b1;
            end
        end
    end

    assign stall_d = valid_d & ~flush_i & loadHit;

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        selA = '0;
        selB = '0;
        errA = 1'b0;
        errB = 1'b0;
        if (stages[1].valid) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                if (stages[1].rs1 != '0 && prodHit(stages[k], stages[1].rs1)) begin
                    selA = SELW'(k);
                    errA = (k < LOAD_RDY) && stages[k].memToReg;
                end
                if (stages[1].rs2 != '0 && prodHit(stages[k], stages[1].rs2)) begin
                    selB = SELW'(k);
                    errB = (k < LOAD_RDY) && stages[k].memToReg;
                end
            end
        end
    end

    assign fwd_a_e = selA;
    assign fwd_b_e = selB;
    assign fwd_err = errA | errB;

    always_comb begin
        valid_o = '0;
        for (int k = 1; k <= NSTAGE; k++) begin
            valid_o[k-1] = stages[k].valid;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_d && !hold_i) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

endmodule
